id_stage_regfile: RTL and testbench
===================================

Name: id_stage_regfile

Overview:
- Parametrised instruction-decode stage for the pipelined MIPS core, successor to the fixed 32x32 decode block.
- Contains a register file with configurable width and depth, a write-back port and a jal link port, both with same-cycle bypass.
- Adds a registered ID/EX output stage with valid, stall and flush control.
- Produces operands, register addresses, the extended immediate and the branch target one cycle after the instruction is presented.

Parameters:
DATA_W, 32, register/operand width in bits (>= 16)
NREG, 32, number of architectural registers (power of two, <= 32)
AW, 5, register address width = log2(NREG)
PC_W, 32, program-counter width
ZERO_REG, 1, 1 = register 0 hardwired to zero and writes to it are dropped

Ports:
clk  in  1  clock, rising-edge
reset_n  in  1  synchronous active-low reset
in_valid  in  1  instruction/pc inputs hold a valid instruction
stall  in  1  hold the ID/EX outputs (hazard stall)
flush  in  1  kill the instruction being captured; insert a bubble
instruction  in  32  MIPS instruction word
pc  in  PC_W  PC+4 of the instruction
wb_en  in  1  write-back enable
wb_addr  in  AW  write-back register
wb_data  in  DATA_W  write-back value
link_en  in  1  jal link write into register NREG-1
link_pc  in  PC_W  link value; zero-extended or truncated to DATA_W
out_valid  out  1  ID/EX slot holds a valid instruction
rs_val  out  DATA_W  rs operand
rt_val  out  DATA_W  rt operand
rs_addr  out  AW  instruction[21+AW-1:21]
rt_addr  out  AW  instruction[16+AW-1:16]
rd_addr  out  AW  instruction[11+AW-1:11]
shamt  out  5  instruction[10:6]
ext_imm  out  DATA_W  extended immediate
pc_branch  out  PC_W  branch target
out_pc  out  PC_W  registered pc

Behaviour:
- All state updates on rising clk only.
- Reset (reset_n = 0 at the edge):
  - every register-file entry is cleared to 0;
  - all outputs are cleared to 0, including out_valid;
  - reset overrides stall, flush and both write ports.
- Register-file writes:
  - A write occurs when wb_en = 1, or when link_en = 1 (target NREG-1).
  - With ZERO_REG = 1, any write to register 0 is dropped.
  - If both ports target NREG-1 in the same cycle, the link value wins (jal is younger than the instruction in write-back).
  - Writes happen regardless of stall and flush.
- Read and bypass: the operand captured for address A is resolved in this order:
  - link_pc, if link_en = 1 and A = NREG-1;
  - else wb_data, if wb_en = 1, wb_addr = A, and A is not a dropped register 0;
  - else the stored entry.
  - Register 0 always reads 0 when ZERO_REG = 1.
- Capture (no reset, stall = 0, flush = 0):
  - all outputs are loaded from the current inputs; latency is 1 cycle;
  - out_valid <= in_valid;
  - fields and operands are loaded even when in_valid = 0.
- Immediate extension:
  - opcode instruction[31:26] in {0x0C, 0x0D, 0x0E} zero-extends imm[15:0] to DATA_W;
  - all other opcodes sign-extend.
- Branch target: pc_branch <= pc + (sign-extended imm << 2), computed at PC_W and truncated. It is registered together with ext_imm, not derived combinationally from outputs.
- Stall (stall = 1, flush = 0):
  - all outputs hold their values;
  - exception: rs_val / rt_val are refreshed when the bypass rule hits the held rs_addr / rt_addr, so a stalled operand never goes stale.
- Flush (flush = 1):
  - out_valid <= 0 and every other output <= 0;
  - flush has priority over stall.
- Wrap-around: pc_branch arithmetic is modulo 2^PC_W.

Test Plan:
1. Reset then capture: hold reset_n = 0 for 2 cycles → all outputs 0. Present addi $3,$0,-4 (0x2003FFFC), pc = 0x100, in_valid = 1 → next cycle out_valid = 1, rt_addr = 3, ext_imm = 0xFFFFFFFC, pc_branch = 0xF0.
2. Zero extension: ori $2,$1,0x8000 (0x34228000) → ext_imm = 0x00008000; pc_branch still uses sign extension = pc - 0x20000.
3. Bypass: wb_en = 1, wb_addr = 5, wb_data = 0xDEADBEEF in the same cycle an instruction with rs = 5 is presented → rs_val = 0xDEADBEEF. A write to $0 with value 7 → reads of $0 return 0.
4. Link conflict: link_en = 1, link_pc = 0x400, and wb_en = 1, wb_addr = 31, wb_data = 0x55 in the same cycle → $31 reads 0x400 on the next access.
5. Stall refresh: capture an instruction with rt = 8, then stall = 1 for 3 cycles. During the stall, write $8 = 0x1234 → rt_val becomes 0x1234 on the following edge; all other outputs, including out_valid = 1, are unchanged.
6. Flush priority and reset mid-flight:
   - stall = 1 and flush = 1 together → out_valid = 0, outputs 0.
   - reset_n = 0 asserted with wb_en = 1 → the write is discarded and the register reads 0 afterwards.

Source files
------------

// File: rtl/id_stage_regfile_if.sv
// Signal bundle between the decode stage and its neighbours: instruction
// fetch inputs, the two register-file write ports, and the ID/EX slot.
interface id_stage_regfile_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int PC_W   = 32
);
  logic              in_valid;
  logic              stall;
  logic              flush;
  logic [31:0]       instruction;
  logic [PC_W-1:0]   pc;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              link_en;
  logic [PC_W-1:0]   link_pc;

  logic              out_valid;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [AW-1:0]     rs_addr;
  logic [AW-1:0]     rt_addr;
  logic [AW-1:0]     rd_addr;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] ext_imm;
  logic [PC_W-1:0]   pc_branch;
  logic [PC_W-1:0]   out_pc;

  modport slave (
    input  in_valid, stall, flush, instruction, pc,
           wb_en, wb_addr, wb_data, link_en, link_pc,
    output out_valid, rs_val, rt_val, rs_addr, rt_addr, rd_addr,
           shamt, ext_imm, pc_branch, out_pc
  );

  modport master (
    output in_valid, stall, flush, instruction, pc,
           wb_en, wb_addr, wb_data, link_en, link_pc,
    input  out_valid, rs_val, rt_val, rs_addr, rt_addr, rd_addr,
           shamt, ext_imm, pc_branch, out_pc
  );
endinterface

// File: rtl/id_stage_regfile.sv
// MIPS instruction-decode stage: bypassed register file with write-back and
// jal link ports, feeding a registered ID/EX slot with stall and flush.
module id_stage_regfile #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int PC_W     = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  id_stage_regfile_if.slave  bus
);

  localparam logic [AW-1:0] LINK_REG = AW'(NREG - 1);

  logic [DATA_W-1:0] rf [NREG];

  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              link_en;
  logic [DATA_W-1:0] link_val;

  assign wb_en    = bus.wb_en;
  assign wb_addr  = bus.wb_addr;
  assign wb_data  = bus.wb_data;
  assign link_en  = bus.link_en;
  assign link_val = DATA_W'(bus.link_pc);

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // True when a write landing this cycle targets address a.
  function automatic logic bypass_hit(input logic [AW-1:0] a);
    return (link_en && a == LINK_REG) ||
           (wb_en && wb_addr == a && !is_zero_reg(a));
  endfunction

  // Operand resolution: hardwired zero, then link (younger jal), then
  // write-back, then the stored entry.
  function automatic logic [DATA_W-1:0] read_op(input logic [AW-1:0] a);
    if (is_zero_reg(a))                  return '0;
    else if (link_en && a == LINK_REG)   return link_val;
    else if (wb_en && wb_addr == a)      return wb_data;
    else                                 return rf[a];
  endfunction

  // NOTE: the register file is cleared on reset because software relies on
  // every register reading zero after reset; most RAM arrays should not be.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (!is_zero_reg(AW'(i))) begin
          if (link_en && AW'(i) == LINK_REG)          rf[i] <= link_val;
          else if (wb_en && wb_addr == AW'(i))        rf[i] <= wb_data;
        end
      end
    end
  end

  // Decode of the presented instruction.
  logic [5:0]        opcode;
  logic [15:0]       imm;
  logic [AW-1:0]     rs_a, rt_a, rd_a;
  logic [DATA_W-1:0] ext_imm_d;
  logic [PC_W-1:0]   br_off;

  assign opcode = bus.instruction[31:26];
  assign imm    = bus.instruction[15:0];
  assign rs_a   = bus.instruction[21 +: AW];
  assign rt_a   = bus.instruction[16 +: AW];
  assign rd_a   = bus.instruction[11 +: AW];
  assign br_off = PC_W'($signed(imm));

  // NOTE: every variable written in always_comb gets a value on every path
  // (default first), otherwise synthesis infers a latch.
  always_comb begin
    ext_imm_d = DATA_W'($signed(imm));
    if (opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E)
      ext_imm_d = DATA_W'(imm);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n || bus.flush) begin
      bus.out_valid <= 1'b0;
      bus.rs_val    <= '0;
      bus.rt_val    <= '0;
      bus.rs_addr   <= '0;
      bus.rt_addr   <= '0;
      bus.rd_addr   <= '0;
      bus.shamt     <= '0;
      bus.ext_imm   <= '0;
      bus.pc_branch <= '0;
      bus.out_pc    <= '0;
    end else if (!bus.stall) begin
      bus.out_valid <= bus.in_valid;
      bus.rs_val    <= read_op(rs_a);
      bus.rt_val    <= read_op(rt_a);
      bus.rs_addr   <= rs_a;
      bus.rt_addr   <= rt_a;
      bus.rd_addr   <= rd_a;
      bus.shamt     <= bus.instruction[10:6];
      bus.ext_imm   <= ext_imm_d;
      bus.pc_branch <= bus.pc + (br_off << 2);
      bus.out_pc    <= bus.pc;
    end else begin
      // Held operands follow writes to their registers so they never go stale.
      if (bypass_hit(bus.rs_addr)) bus.rs_val <= read_op(bus.rs_addr);
      if (bypass_hit(bus.rt_addr)) bus.rt_val <= read_op(bus.rt_addr);
    end
  end

endmodule

// File: tb/tb_id_stage_regfile.sv
// Directed vectors and hand sequences for the decode stage with its
// register file, bypass, stall refresh, flush and reset behaviour.
module tb_id_stage_regfile;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  id_stage_regfile_if #(.DATA_W(32), .AW(5), .PC_W(32)) bus_if ();

  id_stage_regfile #(
    .DATA_W(32), .NREG(32), .AW(5), .PC_W(32), .ZERO_REG(1'b1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        link_en;
    logic [31:0] link_pc;
    logic        e_valid;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_ext;
    logic [31:0] e_br;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_slot(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic valid, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [31:0] ext, input logic [31:0] br);
    check({tag, ".out_valid"}, 32'(bus_if.out_valid), 32'(valid));
    check({tag, ".rs_val"},    bus_if.rs_val,    rs);
    check({tag, ".rt_val"},    bus_if.rt_val,    rt);
    check({tag, ".rs_addr"},   32'(bus_if.rs_addr), 32'(instr[25:21]));
    check({tag, ".rt_addr"},   32'(bus_if.rt_addr), 32'(instr[20:16]));
    check({tag, ".rd_addr"},   32'(bus_if.rd_addr), 32'(instr[15:11]));
    check({tag, ".shamt"},     32'(bus_if.shamt),   32'(instr[10:6]));
    check({tag, ".ext_imm"},   bus_if.ext_imm,   ext);
    check({tag, ".pc_branch"}, bus_if.pc_branch, br);
    check({tag, ".out_pc"},    bus_if.out_pc,    pc);
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic le, input logic [31:0] lp,
                       input logic st, input logic fl);
    bus_if.in_valid    = v;
    bus_if.instruction = instr;
    bus_if.pc          = pc;
    bus_if.wb_en       = we;
    bus_if.wb_addr     = wa;
    bus_if.wb_data     = wd;
    bus_if.link_en     = le;
    bus_if.link_pc     = lp;
    bus_if.stall       = st;
    bus_if.flush       = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          valid instr         pc            we  wa  wd            le  lp          ev  rs            rt            ext           br
    vecs[0] = '{1'b1, 32'h2003FFFC, 32'h00000100, 0, 0,  32'h0,        0, 32'h0,   1'b1, 32'h0,        32'h0,        32'hFFFFFFFC, 32'h000000F0};
    vecs[1] = '{1'b1, 32'h34228000, 32'h00020100, 0, 0,  32'h0,        0, 32'h0,   1'b1, 32'h0,        32'h0,        32'h00008000, 32'h00000100};
    vecs[2] = '{1'b1, 32'h00A63820, 32'h00000200, 1, 5,  32'hDEADBEEF, 0, 32'h0,   1'b1, 32'hDEADBEEF, 32'h0,        32'h00003820, 32'h0000E280};
    vecs[3] = '{1'b0, 32'h00050000, 32'h00000300, 1, 0,  32'h7,        0, 32'h0,   1'b0, 32'h0,        32'hDEADBEEF, 32'h0,        32'h00000300};
    vecs[4] = '{1'b1, 32'h001F0000, 32'h00000400, 1, 31, 32'h55,       1, 32'h400, 1'b1, 32'h0,        32'h00000400, 32'h0,        32'h00000400};
    vecs[5] = '{1'b1, 32'h3BE5FFFF, 32'h00000500, 0, 0,  32'h0,        0, 32'h0,   1'b1, 32'h00000400, 32'hDEADBEEF, 32'h0000FFFF, 32'h000004FC};
    vecs[6] = '{1'b1, 32'h10637FFF, 32'hFFFFFFF0, 0, 0,  32'h0,        0, 32'h0,   1'b1, 32'h0,        32'h0,        32'h00007FFF, 32'h0001FFEC};
    vecs[7] = '{1'b1, 32'h30A88001, 32'h00001000, 0, 0,  32'h0,        0, 32'h0,   1'b1, 32'hDEADBEEF, 32'h0,        32'h00008001, 32'hFFFE1004};

    reset_n = 1'b0;
    drive(1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1, 5'd4, 32'h99, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    check_slot("reset", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].in_valid, vecs[i].instr, vecs[i].pc, vecs[i].wb_en, vecs[i].wb_addr,
            vecs[i].wb_data, vecs[i].link_en, vecs[i].link_pc, 1'b0, 1'b0);
      tick();
      check_slot($sformatf("vec%0d", i), vecs[i].instr, vecs[i].pc, vecs[i].e_valid,
                 vecs[i].e_rs, vecs[i].e_rt, vecs[i].e_ext, vecs[i].e_br);
    end

    // Stall holds the andi slot (rt = 8) while new inputs are presented.
    drive(1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check_slot("stall1", 32'h30A88001, 32'h1000, 1'b1, 32'hDEADBEEF, 32'h0, 32'h8001, 32'hFFFE1004);
    drive(1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 5'd8, 32'h1234, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check_slot("stall2", 32'h30A88001, 32'h1000, 1'b1, 32'hDEADBEEF, 32'h1234, 32'h8001, 32'hFFFE1004);
    drive(1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check_slot("stall3", 32'h30A88001, 32'h1000, 1'b1, 32'hDEADBEEF, 32'h1234, 32'h8001, 32'hFFFE1004);

    // Flush wins over stall.
    drive(1'b1, 32'h2003FFFC, 32'h100, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    check_slot("flush", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

    // $8 was written during the stall and must be in storage now.
    drive(1'b1, 32'h01000000, 32'h40, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check_slot("rd8", 32'h01000000, 32'h40, 1'b1, 32'h1234, 32'h0, 32'h0, 32'h40);

    // Reset mid-flight discards a concurrent write and clears the file.
    reset_n = 1'b0;
    drive(1'b1, 32'h01280000, 32'h80, 1'b1, 5'd9, 32'hAA, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check_slot("reset2", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    reset_n = 1'b1;
    drive(1'b1, 32'h01280000, 32'h80, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check_slot("post_reset", 32'h01280000, 32'h80, 1'b1, 32'h0, 32'h0, 32'h0, 32'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
